pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central sequencer for the CPU's three pipeline registers: IF/ID, ID/EX and EX/WB.
- Generates the per-stage enable and bubble-insert controls from four sources: memory wait, branch redirect, load-use hazard and HALT/wake.
- Sits between the hazard/decode logic and the pipeline registers; each stage register's enable input is driven directly from this block.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive bubble cycles after a taken branch (legal 1..15).
- CNT_W, 16, width of the stall-cycle counter (see Optional Feature).

Ports:
- i_Clk  in  1  system clock; all state updates on rising edge.
- i_nRst  in  1  synchronous active-low reset.
- i_Mem_Busy  in  1  memory not ready; the pipeline must freeze.
- i_Branch_Taken  in  1  single-cycle pulse: redirect PC and flush younger stages.
- i_Load_Use  in  1  load-use hazard detected in decode.
- i_Halt  in  1  HALT instruction executing.
- i_Wake  in  1  interrupt/wake request.
- i_Count_Clr  in  1  clears the stall counter.
- o_IF_Enable  out  1  PC/fetch and IF/ID register enable.
- o_ID_Enable  out  1  ID/EX register enable.
- o_EX_Enable  out  1  EX/WB register enable.
- o_Bubble_IFID  out  1  select NOP into IF/ID.
- o_Bubble_IDEX  out  1  select NOP into ID/EX.
- o_PC_Load  out  1  load branch target into PC.
- o_Halted  out  1  controller is in HALT.
- o_Stall_Count  out  CNT_W  saturating stall-cycle count.

Behaviour:
- Interface: one clock, i_Clk. Reset i_nRst is synchronous and active-low.
- Outputs are combinational from the registered state and the current inputs, so a stall takes effect in the same cycle it is requested.
- While i_nRst=0: all enables, bubbles, o_PC_Load and o_Halted are 0. On the next edge the state is RUN, pending_flush=0, flush_cnt=0 and o_Stall_Count=0.
- Reset mid-operation behaves identically, whatever the current state.
- Registered state: RUN, MEM_WAIT, FLUSH, HALT; plus pending_flush (1 bit) and flush_cnt (4 bits).

RUN (normal operation: all enables 1, bubbles 0). Priority from highest to lowest:
1. i_Mem_Busy: all enables 0; next state MEM_WAIT; pending_flush <= i_Branch_Taken.
2. i_Branch_Taken: enables 1; o_Bubble_IFID=1, o_Bubble_IDEX=1, o_PC_Load=1. If FLUSH_CYCLES>1: next state FLUSH, flush_cnt <= FLUSH_CYCLES-1. Otherwise stay in RUN.
3. i_Load_Use: o_IF_Enable=0, o_ID_Enable=1 with o_Bubble_IDEX=1, o_EX_Enable=1. Stays in RUN; the bubble lasts only as long as the input is held.
4. i_Halt: enables 1 this cycle so EX retires; next state HALT.

MEM_WAIT:
- While i_Mem_Busy=1: all enables 0; an i_Branch_Taken pulse sets pending_flush.
- On the first cycle with i_Mem_Busy=0: enables 1; if pending_flush or i_Branch_Taken, apply the RUN branch actions (including the FLUSH entry rule).
- pending_flush clears; next state RUN or FLUSH.

FLUSH:
- Enables 1, o_Bubble_IFID=1, o_Bubble_IDEX=1, o_PC_Load=0; flush_cnt decrements.
- flush_cnt==1 moves to RUN on the next edge.
- i_Mem_Busy=1: all enables 0, counter holds.
- A new i_Branch_Taken reloads flush_cnt and asserts o_PC_Load.
- i_Load_Use and i_Halt are ignored.

HALT:
- All enables 0, o_Halted=1.
- i_Wake=1 moves to RUN on the next edge; o_Halted drops the same edge.
- i_Halt and i_Wake both high in RUN: HALT is entered, then left one cycle later.

Optional Feature:
- Macro: STALL_COUNT_EN.
- Defined: o_Stall_Count increments on every non-reset cycle with o_IF_Enable=0 and saturates at all-ones. i_Count_Clr=1 forces 0 on the next edge; clear wins over increment.
- Undefined: the counter logic is absent, o_Stall_Count is constant 0 and i_Count_Clr is ignored.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> enables 0 during reset; the cycle after release shows enables 1, bubbles 0, o_Halted=0.
- i_Mem_Busy high 3 cycles with an i_Branch_Taken pulse in cycle 2 -> enables 0 for 3 cycles; the release cycle shows enables 1 with o_PC_Load=1, o_Bubble_IFID=1, o_Bubble_IDEX=1.
- FLUSH_CYCLES=3, i_Branch_Taken pulse -> bubbles asserted exactly 3 consecutive cycles; o_PC_Load on the first only; then RUN.
- i_Load_Use and i_Branch_Taken high in the same cycle -> branch wins: o_IF_Enable=1, o_PC_Load=1.
- i_Halt pulse, wait 5 cycles, then i_Wake -> o_Halted=1 for those cycles with enables 0; enables return the cycle after i_Wake.
- STALL_COUNT_EN defined, CNT_W=2, 5 load-use cycles -> o_Stall_Count saturates at 3; i_Count_Clr gives 0 next cycle.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush sequencer for the IF/ID, ID/EX and EX/WB registers.
// Sources: memory wait, branch redirect, load-use hazard, HALT/wake.
// Optional macro STALL_COUNT_EN enables the saturating stall-cycle counter.
module pipeline_stall_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_Clk,
  input  logic             i_nRst,
  input  logic             i_Mem_Busy,
  input  logic             i_Branch_Taken,
  input  logic             i_Load_Use,
  input  logic             i_Halt,
  input  logic             i_Wake,
  input  logic             i_Count_Clr,
  output logic             o_IF_Enable,
  output logic             o_ID_Enable,
  output logic             o_EX_Enable,
  output logic             o_Bubble_IFID,
  output logic             o_Bubble_IDEX,
  output logic             o_PC_Load,
  output logic             o_Halted,
  output logic [CNT_W-1:0] o_Stall_Count
);

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_FLUSH, ST_HALT} state_t;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;

  logic if_en, id_en, ex_en, bub_ifid, bub_idex, pc_load, halted;
  logic take_branch;

  // State, pending-flush flag and flush counter registers
  always_ff @(posedge i_Clk) begin
    if (!i_nRst) begin
      state_q     <= ST_RUN;
      pending_q   <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state and stage controls; branch actions are shared by RUN, MEM_WAIT exit and FLUSH reload
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    flush_cnt_d = flush_cnt_q;
    if_en       = 1'b1;
    id_en       = 1'b1;
    ex_en       = 1'b1;
    bub_ifid    = 1'b0;
    bub_idex    = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    take_branch = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (i_Mem_Busy) begin
          if_en     = 1'b0;
          id_en     = 1'b0;
          ex_en     = 1'b0;
          state_d   = ST_MEM_WAIT;
          pending_d = i_Branch_Taken;
        end else if (i_Branch_Taken) begin
          take_branch = 1'b1;
        end else if (i_Load_Use) begin
          if_en    = 1'b0;
          bub_idex = 1'b1;
        end else if (i_Halt) begin
          state_d = ST_HALT;
        end
      end
      ST_MEM_WAIT: begin
        if (i_Mem_Busy) begin
          if_en = 1'b0;
          id_en = 1'b0;
          ex_en = 1'b0;
          if (i_Branch_Taken) pending_d = 1'b1;
        end else begin
          pending_d   = 1'b0;
          state_d     = ST_RUN;
          take_branch = pending_q | i_Branch_Taken;
        end
      end
      ST_FLUSH: begin
        if (i_Mem_Busy) begin
          if_en = 1'b0;
          id_en = 1'b0;
          ex_en = 1'b0;
        end else if (i_Branch_Taken) begin
          take_branch = 1'b1;
        end else begin
          bub_ifid = 1'b1;
          bub_idex = 1'b1;
          if (flush_cnt_q <= 4'd1) begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
      end
      ST_HALT: begin
        if_en  = 1'b0;
        id_en  = 1'b0;
        ex_en  = 1'b0;
        halted = 1'b1;
        if (i_Wake) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (take_branch) begin
      bub_ifid = 1'b1;
      bub_idex = 1'b1;
      pc_load  = 1'b1;
      if (MULTI_FLUSH) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_RELOAD;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  assign o_IF_Enable   = i_nRst & if_en;
  assign o_ID_Enable   = i_nRst & id_en;
  assign o_EX_Enable   = i_nRst & ex_en;
  assign o_Bubble_IFID = i_nRst & bub_ifid;
  assign o_Bubble_IDEX = i_nRst & bub_idex;
  assign o_PC_Load     = i_nRst & pc_load;
  assign o_Halted      = i_nRst & halted;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles where fetch is frozen; clear beats increment
  always_ff @(posedge i_Clk) begin
    if (!i_nRst) begin
      stall_cnt_q <= '0;
    end else if (i_Count_Clr) begin
      stall_cnt_q <= '0;
    end else if (!o_IF_Enable && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign o_Stall_Count = stall_cnt_q;
`else
  logic unused_count_clr;
  assign unused_count_clr = i_Count_Clr;
  assign o_Stall_Count    = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller (FLUSH_CYCLES=3, CNT_W=2).
module tb_pipeline_stall_controller;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          nrst, busy, br, lu, halt, wake, clr;
  logic          ife, ide, exe, bifid, bidex, pcl, hlt;
  logic [CW-1:0] scnt;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [8:0]    exp_q[$];
  string         tag_q[$];
  logic [CW-1:0] exp_cnt = '0;

  // Expected control vectors {IF,ID,EX,BubIFID,BubIDEX,PCLoad,Halted}
  localparam logic [6:0] V_ZERO = 7'b000_0000;
  localparam logic [6:0] V_RUN  = 7'b111_0000;
  localparam logic [6:0] V_STL  = 7'b000_0000;
  localparam logic [6:0] V_BR   = 7'b111_1110;
  localparam logic [6:0] V_FL   = 7'b111_1100;
  localparam logic [6:0] V_LU   = 7'b011_0100;
  localparam logic [6:0] V_HLT  = 7'b000_0001;

  pipeline_stall_controller #(.FLUSH_CYCLES(3), .CNT_W(CW)) dut (
    .i_Clk(clk), .i_nRst(nrst), .i_Mem_Busy(busy), .i_Branch_Taken(br),
    .i_Load_Use(lu), .i_Halt(halt), .i_Wake(wake), .i_Count_Clr(clr),
    .o_IF_Enable(ife), .o_ID_Enable(ide), .o_EX_Enable(exe),
    .o_Bubble_IFID(bifid), .o_Bubble_IDEX(bidex), .o_PC_Load(pcl),
    .o_Halted(hlt), .o_Stall_Count(scnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
               tag, obs[8:2], obs[1:0], expv[8:2], expv[1:0]);
    end
  endtask

  // One cycle: drive inputs after negedge, queue expectation, sample mid-low-phase, pop and compare
  task automatic step(input logic n, input logic b, input logic t, input logic l,
                      input logic h, input logic w, input logic c,
                      input logic [6:0] ctl, input string tag);
    logic [8:0] e;
    string      tg;
    @(negedge clk);
    nrst = n; busy = b; br = t; lu = l; halt = h; wake = w; clr = c;
    exp_q.push_back({ctl, exp_cnt});
    tag_q.push_back(tag);
    #2;
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    check(tg, {ife, ide, exe, bifid, bidex, pcl, hlt, scnt}, e);
`ifdef STALL_COUNT_EN
    if (!n || c)     exp_cnt = '0;
    else if (!ctl[6] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
`endif
  endtask

  task automatic idle(input logic [6:0] ctl, input string tag);
    step(1, 0, 0, 0, 0, 0, 0, ctl, tag);
  endtask

  initial begin
    nrst = 0; busy = 0; br = 0; lu = 0; halt = 0; wake = 0; clr = 0;

    step(0, 0, 0, 0, 0, 0, 0, V_ZERO, "reset0");
    step(0, 0, 0, 0, 0, 0, 0, V_ZERO, "reset1");
    idle(V_RUN, "run_after_reset");

    // memory wait with branch pulse in the second busy cycle
    step(1, 1, 0, 0, 0, 0, 0, V_STL, "mem1");
    step(1, 1, 1, 0, 0, 0, 0, V_STL, "mem2_branch");
    step(1, 1, 0, 0, 0, 0, 0, V_STL, "mem3");
    idle(V_BR, "mem_release_branch");
    idle(V_FL, "mem_flush1");
    idle(V_FL, "mem_flush2");
    idle(V_RUN, "mem_back_run");

    // plain branch: exactly three bubble cycles, PC load first only
    step(1, 0, 1, 0, 0, 0, 0, V_BR, "br");
    idle(V_FL, "br_flush1");
    idle(V_FL, "br_flush2");
    idle(V_RUN, "br_back_run");

    // branch beats load-use
    step(1, 0, 1, 1, 0, 0, 0, V_BR, "br_lu");
    idle(V_FL, "br_lu_flush1");
    idle(V_FL, "br_lu_flush2");
    idle(V_RUN, "br_lu_run");

    // load-use bubble only while held
    step(1, 0, 0, 1, 0, 0, 0, V_LU, "lu");
    idle(V_RUN, "lu_release");

    // halt for five cycles then wake
    step(1, 0, 0, 0, 1, 0, 0, V_RUN, "halt_retire");
    for (int i = 0; i < 5; i++) idle(V_HLT, "halted");
    step(1, 0, 0, 0, 0, 1, 0, V_HLT, "wake_cycle");
    idle(V_RUN, "after_wake");

    // halt and wake together: enter, leave one cycle later
    step(1, 0, 0, 0, 1, 1, 0, V_RUN, "halt_wake");
    step(1, 0, 0, 0, 0, 1, 0, V_HLT, "halt_wake_h");
    idle(V_RUN, "halt_wake_run");

    // flush ignores load-use and halt
    step(1, 0, 1, 0, 0, 0, 0, V_BR, "fl_ign_br");
    step(1, 0, 0, 1, 1, 0, 0, V_FL, "fl_ign1");
    step(1, 0, 0, 1, 1, 0, 0, V_FL, "fl_ign2");
    idle(V_RUN, "fl_ign_run");

    // memory wait during flush holds the counter
    step(1, 0, 1, 0, 0, 0, 0, V_BR, "fl_mem_br");
    step(1, 1, 0, 0, 0, 0, 0, V_STL, "fl_mem_stall");
    idle(V_FL, "fl_mem_flush1");
    idle(V_FL, "fl_mem_flush2");
    idle(V_RUN, "fl_mem_run");

    // new branch during flush reloads the counter
    step(1, 0, 1, 0, 0, 0, 0, V_BR, "fl_re_br");
    idle(V_FL, "fl_re_flush1");
    step(1, 0, 1, 0, 0, 0, 0, V_BR, "fl_re_br2");
    idle(V_FL, "fl_re_flush2");
    idle(V_FL, "fl_re_flush3");
    idle(V_RUN, "fl_re_run");

    // stall counter: clear, saturate, clear, clear beats increment
    step(1, 0, 0, 0, 0, 0, 1, V_RUN, "cnt_clr");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 0, 0, V_LU, "cnt_lu");
    idle(V_RUN, "cnt_sat");
    step(1, 0, 0, 1, 0, 0, 1, V_LU, "cnt_clr_lu");
    idle(V_RUN, "cnt_cleared");

    // reset from HALT
    step(1, 0, 0, 0, 1, 0, 0, V_RUN, "pre_rst_halt");
    idle(V_HLT, "pre_rst_halted");
    step(0, 0, 0, 0, 0, 0, 0, V_ZERO, "mid_reset");
    idle(V_RUN, "after_mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, required completion within 20000 time units");
    $fatal(1);
  end

endmodule
